proc_glb_responder: RTL and testbench

PROC_GLB_RESPONDER -- requirements
Module: proc_glb_responder

---
 rtl/proc_glb_responder.sv | 116 +++++++++++
 tb/tb_proc_glb_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/proc_glb_responder.sv
// proc_glb_responder: byte-strobed memory responder with fixed-latency, in-order reads.
// Optional PROC_RSP_COUNTERS_EN adds saturating wr_cnt/rd_cnt request counters.
module proc_glb_responder #(
    parameter int BANK_DATA_WIDTH = 64,
    parameter int GLB_ADDR_WIDTH  = 22,
    parameter int MEM_DEPTH_LOG2  = 8,
    parameter int RD_LATENCY      = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [BANK_DATA_WIDTH/8-1:0] wr_strb,
    input  logic [GLB_ADDR_WIDTH-1:0]    wr_addr,
    input  logic [BANK_DATA_WIDTH-1:0]   wr_data,
    input  logic                         rd_en,
    input  logic [GLB_ADDR_WIDTH-1:0]    rd_addr,
    output logic [BANK_DATA_WIDTH-1:0]   rd_data,
    output logic                         rd_data_valid,
    output logic                         addr_err
`ifdef PROC_RSP_COUNTERS_EN
    ,
    output logic [15:0]                  wr_cnt,
    output logic [15:0]                  rd_cnt
`endif
);
    localparam int NB    = BANK_DATA_WIDTH / 8;
    localparam int B     = $clog2(NB);
    localparam int HI    = B + MEM_DEPTH_LOG2;
    localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

    logic [BANK_DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [MEM_DEPTH_LOG2-1:0]  wr_idx, rd_idx;
    logic                       wr_oor, rd_oor, wr_ok, rd_ok;

    assign wr_idx = wr_addr[HI-1:B];
    assign rd_idx = rd_addr[HI-1:B];

    generate
        if (GLB_ADDR_WIDTH > HI) begin : g_oor
            assign wr_oor = |wr_addr[GLB_ADDR_WIDTH-1:HI];
            assign rd_oor = |rd_addr[GLB_ADDR_WIDTH-1:HI];
        end else begin : g_no_oor
            assign wr_oor = 1'b0;
            assign rd_oor = 1'b0;
        end
        if (B > 0) begin : g_lo
            logic unused_lo;
            assign unused_lo = ^{wr_addr[B-1:0], rd_addr[B-1:0]};
        end
    endgenerate

    assign wr_ok = wr_en && !wr_oor;
    assign rd_ok = rd_en && !rd_oor;

    // Backing store is deliberately not reset; it keeps contents across rst_n.
    always_ff @(posedge clk) begin
        if (wr_ok)
            for (int i = 0; i < NB; i++)
                if (wr_strb[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
    end

    logic [RD_LATENCY-1:0]                      vld_q, vld_d;
    logic [RD_LATENCY-1:0][BANK_DATA_WIDTH-1:0] dat_q, dat_d;
    logic                                       err_q, err_d;

    // Stage 0 samples the array with the pre-write contents, giving read-before-write.
    always_comb begin
        vld_d    = vld_q;
        dat_d    = dat_q;
        vld_d[0] = rd_en;
        dat_d[0] = rd_ok ? mem_q[rd_idx] : '0;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
        err_d = err_q || (wr_en && wr_oor) || (rd_en && rd_oor);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            dat_q <= '0;
            err_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
            err_q <= err_d;
        end
    end

    assign rd_data_valid = vld_q[RD_LATENCY-1];
    assign rd_data       = dat_q[RD_LATENCY-1];
    assign addr_err      = err_q;

`ifdef PROC_RSP_COUNTERS_EN
    logic [15:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

    always_comb begin
        wr_cnt_d = (wr_en && wr_cnt_q != 16'hFFFF) ? wr_cnt_q + 16'd1 : wr_cnt_q;
        rd_cnt_d = (rd_en && rd_cnt_q != 16'hFFFF) ? rd_cnt_q + 16'd1 : rd_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign wr_cnt = wr_cnt_q;
    assign rd_cnt = rd_cnt_q;
`endif
endmodule

// File: tb/tb_proc_glb_responder.sv
// tb_proc_glb_responder: directed + random checks against a byte-array model with a due-cycle response queue.
module tb_proc_glb_responder;
    localparam int W  = 64;
    localparam int AW = 22;
    localparam int L  = 2;
    localparam int MEM_BYTES = 2048;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_strb = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [W-1:0]  rd_data;
    logic          rd_data_valid;
    logic          addr_err;
`ifdef PROC_RSP_COUNTERS_EN
    logic [15:0]   wr_cnt, rd_cnt;
    int            m_wc = 0, m_rc = 0;
`endif

    proc_glb_responder #(.BANK_DATA_WIDTH(W), .GLB_ADDR_WIDTH(AW), .MEM_DEPTH_LOG2(8), .RD_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_strb(wr_strb), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_data_valid(rd_data_valid), .addr_err(addr_err)
`ifdef PROC_RSP_COUNTERS_EN
        , .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [W-1:0] d; } rsp_t;
    rsp_t        q[$];
    logic [7:0]  mb [MEM_BYTES];
    logic        m_err = 1'b0;
    int          edge_n = 0;
    int          vecs = 0;
    int          errs = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mread(input int a);
        logic [W-1:0] r = '0;
        if (a < MEM_BYTES)
            for (int i = 0; i < 8; i++) r[8*i +: 8] = mb[a - a % 8 + i];
        return r;
    endfunction

    task automatic check_outputs();
        logic          ev = 1'b0;
        logic [W-1:0]  ed = '0;
        if (q.size() > 0 && q[0].due == edge_n) begin
            ev = 1'b1;
            ed = q[0].d;
            void'(q.pop_front());
        end
        chk("rd_data_valid", {63'd0, rd_data_valid}, {63'd0, ev});
        chk("rd_data", rd_data, ed);
        chk("addr_err", {63'd0, addr_err}, {63'd0, m_err});
`ifdef PROC_RSP_COUNTERS_EN
        chk("wr_cnt", {48'd0, wr_cnt}, W'(m_wc));
        chk("rd_cnt", {48'd0, rd_cnt}, W'(m_rc));
`endif
    endtask

    // Entered and left at a negedge: drive, let the DUT sample, update model, check.
    task automatic cyc(input logic we, input logic [7:0] st, input int wa, input logic [W-1:0] wd,
                       input logic re, input int ra);
        wr_en = we; wr_strb = st; wr_addr = AW'(wa); wr_data = wd;
        rd_en = re; rd_addr = AW'(ra);
        @(posedge clk);
        edge_n++;
        if (rst_n) begin
            if (re) q.push_back('{edge_n + L - 1, mread(ra)});
            if (we && wa < MEM_BYTES)
                for (int i = 0; i < 8; i++) if (st[i]) mb[wa - wa % 8 + i] = wd[8*i +: 8];
            if ((we && wa >= MEM_BYTES) || (re && ra >= MEM_BYTES)) m_err = 1'b1;
`ifdef PROC_RSP_COUNTERS_EN
            if (we && m_wc < 16'hFFFF) m_wc++;
            if (re && m_rc < 16'hFFFF) m_rc++;
`endif
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 0, '0, 1'b0, 0);
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        #1;
        q.delete();
        m_err = 1'b0;
`ifdef PROC_RSP_COUNTERS_EN
        m_wc = 0;
        m_rc = 0;
`endif
        chk("rst_valid", {63'd0, rd_data_valid}, '0);
        chk("rst_data", rd_data, '0);
        chk("rst_err", {63'd0, addr_err}, '0);
        @(negedge clk);
        idle(n);
        rst_n = 1'b1;
    endtask

    function automatic int rnd_addr();
        return ($urandom_range(0, 15) == 0) ? int'($urandom_range(MEM_BYTES, (1 << AW) - 1))
                                            : int'($urandom_range(0, MEM_BYTES - 1));
    endfunction

    initial begin
        #1;
        chk("init_valid", {63'd0, rd_data_valid}, '0);
        chk("init_data", rd_data, '0);
        chk("init_err", {63'd0, addr_err}, '0);
        @(negedge clk);
        idle(2);
        rst_n = 1'b1;

        for (int a = 0; a < MEM_BYTES; a += 8) cyc(1'b1, 8'hFF, a, {$urandom, $urandom}, 1'b0, 0);

        cyc(1'b1, 8'hFF, 'h10, 64'h1122334455667788, 1'b0, 0);
        cyc(1'b0, 8'h00, 0, '0, 1'b1, 'h10);
        idle(1);
        chk("req031_model", mread('h10), 64'h1122334455667788);
        cyc(1'b1, 8'h0F, 'h10, 64'hAAAAAAAAAAAAAAAA, 1'b0, 0);
        cyc(1'b0, 8'h00, 0, '0, 1'b1, 'h10);
        idle(1);
        chk("req032_model", mread('h10), 64'h11223344AAAAAAAA);

        for (int a = 0; a < 32; a += 8) cyc(1'b0, 8'h00, 0, '0, 1'b1, a);
        idle(L);

        cyc(1'b1, 8'hFF, 'h20, 64'h1, 1'b0, 0);
        cyc(1'b1, 8'hFF, 'h20, 64'h5, 1'b1, 'h20);
        cyc(1'b0, 8'h00, 0, '0, 1'b1, 'h20);
        idle(L);

        cyc(1'b1, 8'h00, 'h28, 64'hDEAD, 1'b1, 'h28);
        idle(L);

        cyc(1'b0, 8'h00, 0, '0, 1'b1, 'h800);
        idle(L);
        cyc(1'b1, 8'hFF, 'h810, 64'hBAD0BAD0BAD0BAD0, 1'b0, 0);
        cyc(1'b0, 8'h00, 0, '0, 1'b1, 'h10);
        idle(L + 2);

        cyc(1'b0, 8'h00, 0, '0, 1'b1, 'h18);
        apply_reset(2);
        cyc(1'b0, 8'h00, 0, '0, 1'b1, 'h10);
        idle(L + 2);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) apply_reset($urandom_range(1, 3));
            cyc(1'($urandom), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), rnd_addr(),
                {$urandom, $urandom}, 1'($urandom), rnd_addr());
        end
        idle(L + 1);
        chk("queue_drained", W'(q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
